// File: rtl/dsp_pkg.sv
// Shared definitions for the DSP Wishbone request arbiter: FSM encoding and parameter limits.
package dsp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT_HI = 3'd2,
    ST_WAIT_LO = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam int START_TIMEOUT_DEF = 15;
  localparam int NUM_REQ_MIN       = 2;
  localparam int NUM_REQ_MAX       = 8;

endpackage

// File: rtl/dsp_rr_arbiter.sv
// Round-robin pick among pending requesters, searching from last_grant+1 and wrapping at NUM_REQ.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller samples the grant only when it can start a transfer.
module dsp_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] pending,
  input  logic [IW-1:0]      last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_idx,
  output logic               valid
);

  logic [IW-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    idx       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IW'((int'(last_grant) + k) % NUM_REQ);
      if (!valid && pending[idx]) begin
        valid      = 1'b1;
        grant_idx  = idx;
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dsp_wb_arbiter.sv
// Shares one Wishbone master port among NUM_REQ requesters, one latched request each.
// Latency: done pulse 5 cycles plus the master's active time after an uncontended request.
// Backpressure: requests are latched per requester; a repeat while pending is dropped.
module dsp_wb_arbiter
  import dsp_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int aw            = 32,
  parameter int dw            = 32,
  parameter int START_TIMEOUT = START_TIMEOUT_DEF
) (
  input  logic                  wb_clk,
  input  logic                  wb_rst,
  input  logic [NUM_REQ-1:0]    req_start,
  input  logic [NUM_REQ*aw-1:0] req_address,
  input  logic [NUM_REQ*4-1:0]  req_selection,
  input  logic [NUM_REQ-1:0]    req_write,
  input  logic [NUM_REQ*dw-1:0] req_data_wr,
  output logic [dw-1:0]         req_data_rd,
  output logic [NUM_REQ-1:0]    req_done,
  output logic [NUM_REQ-1:0]    req_err,
  output logic [NUM_REQ-1:0]    req_pending,
  output logic                  start,
  output logic [aw-1:0]         address,
  output logic [3:0]            selection,
  output logic                  write,
  output logic [dw-1:0]         data_wr,
  input  logic [dw-1:0]         data_rd,
  input  logic                  active
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(START_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(START_TIMEOUT - 1);

  state_t               state;
  logic [IW-1:0]        grant;
  logic [NUM_REQ-1:0]   grant_oh;
  logic [IW-1:0]        last_grant;
  logic [TW-1:0]        tmo_cnt;
  logic [NUM_REQ-1:0]   pend_clr;
  logic [NUM_REQ-1:0]   accept;
  logic [NUM_REQ-1:0]   arb_oh;
  logic [IW-1:0]        arb_idx;
  logic                 arb_vld;

  logic [aw-1:0] hold_addr [NUM_REQ];
  logic [3:0]    hold_sel  [NUM_REQ];
  logic          hold_wr   [NUM_REQ];
  logic [dw-1:0] hold_dat  [NUM_REQ];

  dsp_rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_rr (
    .pending    (req_pending),
    .last_grant (last_grant),
    .grant      (arb_oh),
    .grant_idx  (arb_idx),
    .valid      (arb_vld)
  );

  always_comb begin
    pend_clr = '0;
    if (state == ST_DONE)
      pend_clr = grant_oh;
    else if (state == ST_WAIT_HI && !active && tmo_cnt == TMO_LAST)
      pend_clr = grant_oh;
  end

  // A request landing on the cycle its pending bit clears is taken as a fresh one.
  assign accept = req_start & (~req_pending | pend_clr);

  always_ff @(posedge wb_clk) begin
    if (!wb_rst) begin
      req_pending <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        hold_addr[i] <= '0;
        hold_sel[i]  <= '0;
        hold_wr[i]   <= 1'b0;
        hold_dat[i]  <= '0;
      end
    end else begin
      req_pending <= (req_pending & ~pend_clr) | accept;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accept[i]) begin
          hold_addr[i] <= req_address[i*aw +: aw];
          hold_sel[i]  <= req_selection[i*4 +: 4];
          hold_wr[i]   <= req_write[i];
          hold_dat[i]  <= req_data_wr[i*dw +: dw];
        end
      end
    end
  end

  always_ff @(posedge wb_clk) begin
    if (!wb_rst) begin
      state       <= ST_IDLE;
      start       <= 1'b0;
      address     <= '0;
      selection   <= '0;
      write       <= 1'b0;
      data_wr     <= '0;
      req_data_rd <= '0;
      req_done    <= '0;
      req_err     <= '0;
      grant       <= '0;
      grant_oh    <= '0;
      last_grant  <= IW'(NUM_REQ - 1);
      tmo_cnt     <= '0;
    end else begin
      start    <= 1'b0;
      req_done <= '0;
      req_err  <= '0;
      case (state)
        ST_IDLE: begin
          if (arb_vld) begin
            grant     <= arb_idx;
            grant_oh  <= arb_oh;
            address   <= hold_addr[arb_idx];
            selection <= hold_sel[arb_idx];
            write     <= hold_wr[arb_idx];
            data_wr   <= hold_dat[arb_idx];
            start     <= 1'b1;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          tmo_cnt <= '0;
          state   <= ST_WAIT_HI;
        end
        ST_WAIT_HI: begin
          if (active) begin
            state <= ST_WAIT_LO;
          end else if (tmo_cnt == TMO_LAST) begin
            req_err    <= grant_oh;
            last_grant <= grant;
            state      <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_WAIT_LO: begin
          if (!active) begin
            req_data_rd <= data_rd;
            state       <= ST_DONE;
          end
        end
        ST_DONE: begin
          req_done   <= grant_oh;
          last_grant <= grant;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dsp_wb_arbiter.sv
// Directed bench for dsp_wb_arbiter with a small behavioural Wishbone master.
module tb_dsp_wb_arbiter;

  localparam int NR = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic             wb_clk = 1'b0;
  logic             wb_rst = 1'b0;
  logic [NR-1:0]    req_start = '0;
  logic [NR*AW-1:0] req_address = '0;
  logic [NR*4-1:0]  req_selection = '0;
  logic [NR-1:0]    req_write = '0;
  logic [NR*DW-1:0] req_data_wr = '0;
  logic [DW-1:0]    req_data_rd;
  logic [NR-1:0]    req_done;
  logic [NR-1:0]    req_err;
  logic [NR-1:0]    req_pending;
  logic             start;
  logic [AW-1:0]    address;
  logic [3:0]       selection;
  logic             write;
  logic [DW-1:0]    data_wr;
  logic [DW-1:0]    data_rd = '0;
  logic             active = 1'b0;

  dsp_wb_arbiter #(.NUM_REQ(NR), .aw(AW), .dw(DW), .START_TIMEOUT(15)) dut (
    .wb_clk        (wb_clk),
    .wb_rst        (wb_rst),
    .req_start     (req_start),
    .req_address   (req_address),
    .req_selection (req_selection),
    .req_write     (req_write),
    .req_data_wr   (req_data_wr),
    .req_data_rd   (req_data_rd),
    .req_done      (req_done),
    .req_err       (req_err),
    .req_pending   (req_pending),
    .start         (start),
    .address       (address),
    .selection     (selection),
    .write         (write),
    .data_wr       (data_wr),
    .data_rd       (data_rd),
    .active        (active)
  );

  always #5 wb_clk = ~wb_clk;

  int cyc = 0;
  always @(posedge wb_clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Master: after seeing start, holds active for mst_len cycles, then returns rd_val.
  int          mst_len = 1;
  logic [31:0] rd_val = '0;
  initial begin
    forever begin
      @(negedge wb_clk);
      if (start && mst_len > 0) begin
        @(posedge wb_clk);
        #1 active = 1'b1;
        repeat (mst_len) @(posedge wb_clk);
        #1 active = 1'b0;
        data_rd = rd_val;
        @(posedge wb_clk);
        #1 data_rd = 32'h0BAD_0BAD;
      end
    end
  end

  int          start_cnt = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;
  int          start_cyc = 0;
  logic [31:0] st_addr = '0;
  logic [3:0]  st_sel = '0;
  logic        st_wr = 1'b0;
  logic [31:0] st_dat = '0;
  always @(negedge wb_clk) begin
    if (start) begin
      start_cnt++;
      start_cyc = cyc;
      st_addr   = address;
      st_sel    = selection;
      st_wr     = write;
      st_dat    = data_wr;
    end
    if (req_done != '0) done_cnt++;
    if (req_err != '0) err_cnt++;
  end

  task automatic tick();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic do_reset();
    wb_rst = 1'b0;
    tick();
    tick();
    wb_rst = 1'b1;
    tick();
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [3:0] s,
                         input logic w, input logic [31:0] d);
    req_address[i*AW +: AW] = a;
    req_selection[i*4 +: 4] = s;
    req_write[i]            = w;
    req_data_wr[i*DW +: DW] = d;
  endtask

  task automatic fire(input logic [NR-1:0] mask);
    req_start = mask;
    @(posedge wb_clk);
    #1 req_start = '0;
  endtask

  task automatic wait_done(input int budget, output int idx, output int at);
    idx = -1;
    at  = -1;
    for (int n = 0; n < budget; n++) begin
      @(negedge wb_clk);
      if (req_done != '0) begin
        at = cyc;
        for (int k = 0; k < NR; k++) if (req_done[k]) idx = k;
        break;
      end
    end
    if (idx < 0) chk("done_timeout", 0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, at, t0, s0, d0, e0, ecyc;
    logic [NR-1:0] evec, epend;

    tick();
    tick();
    chk("rst_start", start, 0);
    chk("rst_pending", req_pending, 0);
    chk("rst_done", req_done, 0);
    chk("rst_err", req_err, 0);
    chk("rst_addr", address, 0);
    chk("rst_rd", req_data_rd, 0);
    wb_rst = 1'b1;
    tick();

    // Single write from requester 2, active high 3 cycles
    mst_len = 3;
    rd_val  = 32'h1111_1111;
    set_req(2, 32'h100, 4'hF, 1'b1, 32'hDEAD_BEEF);
    t0 = cyc;
    s0 = start_cnt;
    fire(4'b0100);
    chk("t1_pending", req_pending, 4'b0100);
    wait_done(40, idx, at);
    chk("t1_idx", idx, 2);
    chk("t1_latency", at - t0, 8);
    chk("t1_issue_cyc", start_cyc - t0, 2);
    chk("t1_addr", st_addr, 32'h100);
    chk("t1_sel", st_sel, 4'hF);
    chk("t1_wr", st_wr, 1);
    chk("t1_dat", st_dat, 32'hDEAD_BEEF);
    chk("t1_nstart", start_cnt - s0, 1);
    chk("t1_addr_hold", address, 32'h100);
    chk("t1_pend_clr", req_pending, 0);
    chk("t1_rd", req_data_rd, 32'h1111_1111);

    // All four at once after reset: order 0,1,2,3
    do_reset();
    mst_len = 1;
    for (int i = 0; i < NR; i++) set_req(i, 32'h1000 + i * 32'h100, 4'(i + 1), 1'b0, 32'h0);
    fire(4'b1111);
    for (int k = 0; k < NR; k++) begin
      wait_done(40, idx, at);
      chk("t2_order", idx, k);
      chk("t2_addr", st_addr, 32'h1000 + k * 32'h100);
    end

    // Wrap after grant 3: requesters 0 and 2 -> 0 first
    set_req(0, 32'h2000, 4'h1, 1'b0, 32'h0);
    set_req(2, 32'h2200, 4'h1, 1'b0, 32'h0);
    tick();
    fire(4'b0101);
    wait_done(40, idx, at);
    chk("t2_wrap_first", idx, 0);
    wait_done(40, idx, at);
    chk("t2_wrap_second", idx, 2);

    // Repeat request while pending is dropped
    tick();
    s0 = start_cnt;
    set_req(1, 32'h200, 4'h3, 1'b1, 32'h55);
    fire(4'b0010);
    set_req(1, 32'h300, 4'h3, 1'b1, 32'h66);
    fire(4'b0010);
    wait_done(40, idx, at);
    chk("t3_idx", idx, 1);
    chk("t3_addr", st_addr, 32'h200);
    repeat (20) tick();
    chk("t3_nstart", start_cnt - s0, 1);
    chk("t3_pending", req_pending, 0);

    // Timeout on requester 0, then requester 2 gets served
    do_reset();
    mst_len = 0;
    set_req(0, 32'h400, 4'h1, 1'b0, 32'h0);
    set_req(2, 32'h420, 4'h1, 1'b0, 32'h0);
    fire(4'b0101);
    ecyc  = -1;
    evec  = '0;
    epend = '0;
    for (int n = 0; n < 40; n++) begin
      @(negedge wb_clk);
      if (req_err != '0) begin
        ecyc  = cyc;
        evec  = req_err;
        epend = req_pending;
        break;
      end
    end
    mst_len = 2;
    chk("t4_err_cyc", ecyc - start_cyc, 16);
    chk("t4_err_vec", evec, 4'b0001);
    chk("t4_pending", epend, 4'b0100);
    wait_done(40, idx, at);
    chk("t4_next", idx, 2);

    // New request on the cycle pending clears is kept
    mst_len = 1;
    tick();
    set_req(3, 32'h500, 4'h1, 1'b1, 32'h1);
    fire(4'b1000);
    repeat (4) tick();
    set_req(3, 32'h580, 4'h2, 1'b1, 32'h2);
    fire(4'b1000);
    @(negedge wb_clk);
    chk("t5_done", req_done, 4'b1000);
    chk("t5_repend", req_pending, 4'b1000);
    wait_done(40, idx, at);
    chk("t5_idx", idx, 3);
    chk("t5_addr", st_addr, 32'h580);

    // Read data captured at completion and held afterwards
    rd_val = 32'hCAFE_F00D;
    tick();
    set_req(1, 32'h600, 4'h3, 1'b0, 32'h0);
    fire(4'b0010);
    wait_done(40, idx, at);
    chk("t6_rd_done", req_data_rd, 32'hCAFE_F00D);
    repeat (10) tick();
    chk("t6_rd_hold", req_data_rd, 32'hCAFE_F00D);

    // Reset during WAIT_LO abandons the transfer
    mst_len = 5;
    tick();
    d0 = done_cnt;
    e0 = err_cnt;
    set_req(1, 32'h700, 4'hF, 1'b1, 32'h77);
    fire(4'b0010);
    at = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge wb_clk);
      if (active) begin
        at = cyc;
        break;
      end
    end
    chk("t7_active_seen", (at >= 0), 1);
    tick();
    wb_rst = 1'b0;
    tick();
    chk("t7_start", start, 0);
    chk("t7_pending", req_pending, 0);
    chk("t7_done", req_done, 0);
    chk("t7_err", req_err, 0);
    chk("t7_addr", address, 0);
    chk("t7_sel", selection, 0);
    chk("t7_wr", write, 0);
    chk("t7_dat", data_wr, 0);
    chk("t7_rd", req_data_rd, 0);
    wb_rst = 1'b1;
    repeat (15) tick();
    chk("t7_no_done", done_cnt - d0, 0);
    chk("t7_no_err", err_cnt - e0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
